// File: rtl/multicycle_ctrl_if.sv
// Memory bus between the multicycle controller and the unified
// instruction/data memory: request/strobe/address/size out, data/ready back.
interface multicycle_ctrl_if #(
   parameter int XLEN = 32
);
   logic            mem_req;
   logic            mem_wen;
   logic [XLEN-1:0] mem_addr;
   logic [2:0]      mem_func3;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;

   modport master (
      output mem_req, mem_wen, mem_addr, mem_func3,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_wen, mem_addr, mem_func3,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the RV32I core. Owns PC and instruction
// register, walks each instruction through FETCH -> EXECUTE -> (MEMORY) and
// handshakes with a variable-latency memory. Misaligned accesses, misaligned
// branch/jump targets and illegal action codes divert through TRAP.
module multicycle_ctrl #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h100),
   parameter int              CNT_W       = 64
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_ctrl_if.master   mem,
   input  logic [2:0]          action_type,
   input  logic [2:0]          func3,
   input  logic [XLEN-1:0]     pc_next,
   input  logic [XLEN-1:0]     immediate,
   input  logic [XLEN-1:0]     rs1_data,
   output logic                reg_wen,
   output logic [XLEN-1:0]     pc,
   output logic [31:0]         instruction,
   output logic                retire,
   output logic [CNT_W-1:0]    instret,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [XLEN-1:0]     trap_pc,
   output logic [XLEN-1:0]     trap_addr
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXECUTE,
      S_MEMORY,
      S_TRAP
   } state_t;

   localparam logic [2:0] ACT_STORE  = 3'd0;
   localparam logic [2:0] ACT_LOAD   = 3'd1;
   localparam logic [2:0] ACT_BRANCH = 3'd2;
   localparam logic [2:0] ACT_JAL    = 3'd3;
   localparam logic [2:0] ACT_REG    = 3'd4;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0] CAUSE_LOAD    = 2'd1;
   localparam logic [1:0] CAUSE_STORE   = 2'd2;
   localparam logic [1:0] CAUSE_TARGET  = 2'd3;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] ea;
   logic [XLEN-1:0] ea_calc;
   logic            ea_load;
   logic            ir_load;
   logic            trap_enter;
   logic [1:0]      cause_nxt;
   logic [XLEN-1:0] taddr_nxt;

   // Halfword needs bit 0 clear, word needs bits 1:0 clear, size 11 is never legal.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      case (f3[1:0])
         2'b01:   bad = a[0];
         2'b10:   bad = (a != 2'b00);
         2'b11:   bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   assign ea_calc = rs1_data + immediate;

   // Next-state and all handshake/strobe outputs; everything forced low while reset is held.
   always_comb begin
      state_nxt     = state;
      mem.mem_req   = 1'b0;
      mem.mem_wen   = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_func3 = 3'b000;
      reg_wen       = 1'b0;
      retire        = 1'b0;
      trap          = 1'b0;
      ea_load       = 1'b0;
      ir_load       = 1'b0;
      trap_enter    = 1'b0;
      cause_nxt     = CAUSE_ILLEGAL;
      taddr_nxt     = '0;
      if (!reset) begin
         unique case (state)
            S_FETCH: begin
               mem.mem_req   = 1'b1;
               mem.mem_addr  = pc;
               mem.mem_func3 = 3'b010;
               if (mem.mem_ready) begin
                  ir_load   = 1'b1;
                  state_nxt = S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               case (action_type)
                  ACT_REG: begin
                     reg_wen   = 1'b1;
                     retire    = 1'b1;
                     state_nxt = S_FETCH;
                  end
                  ACT_JAL, ACT_BRANCH: begin
                     if (pc_next[1:0] != 2'b00) begin
                        trap_enter = 1'b1;
                        cause_nxt  = CAUSE_TARGET;
                        taddr_nxt  = pc_next;
                        state_nxt  = S_TRAP;
                     end else begin
                        reg_wen   = (action_type == ACT_JAL);
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                     end
                  end
                  ACT_LOAD, ACT_STORE: begin
                     ea_load = 1'b1;
                     if (misaligned(func3, ea_calc[1:0])) begin
                        trap_enter = 1'b1;
                        cause_nxt  = (action_type == ACT_LOAD) ? CAUSE_LOAD : CAUSE_STORE;
                        taddr_nxt  = ea_calc;
                        state_nxt  = S_TRAP;
                     end else begin
                        state_nxt = S_MEMORY;
                     end
                  end
                  default: begin
                     // No offending data address exists; record the PC instead.
                     trap_enter = 1'b1;
                     cause_nxt  = CAUSE_ILLEGAL;
                     taddr_nxt  = pc;
                     state_nxt  = S_TRAP;
                  end
               endcase
            end
            S_MEMORY: begin
               mem.mem_req   = 1'b1;
               mem.mem_addr  = ea;
               mem.mem_func3 = func3;
               mem.mem_wen   = (action_type == ACT_STORE);
               if (mem.mem_ready) begin
                  reg_wen   = (action_type == ACT_LOAD);
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
            S_TRAP: begin
               trap      = 1'b1;
               state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // PC: pc_next on retirement, trap vector when leaving TRAP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                pc <= RESET_PC;
      else if (retire)          pc <= pc_next;
      else if (state == S_TRAP) pc <= TRAP_VECTOR;
   end

   // Instruction register and effective-address register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= '0;
         ea          <= '0;
      end else begin
         if (ir_load) instruction <= mem.mem_rdata[31:0];
         if (ea_load) ea <= ea_calc;
      end
   end

   // Trap record, captured on the way into TRAP and held until the next trap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_cause <= CAUSE_ILLEGAL;
         trap_pc    <= '0;
         trap_addr  <= '0;
      end else if (trap_enter) begin
         trap_cause <= cause_nxt;
         trap_pc    <= pc;
         trap_addr  <= taddr_nxt;
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table of instruction records run against a
// behavioural memory with programmable wait states, a scoreboard of expected
// retire/trap events, plus hand-written reset-mid-access and counter-wrap sequences.
module tb_multicycle_ctrl;
   localparam int          XLEN = 32;
   localparam logic [31:0] RPC  = 32'h40;
   localparam logic [31:0] TVEC = 32'h100;
   localparam int          CW   = 4;

   localparam logic [2:0] ST = 3'd0, LD = 3'd1, BR = 3'd2, JL = 3'd3, RG = 3'd4;

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0]      action_type, func3;
   logic [31:0]     pc_next, immediate, rs1_data;
   logic            reg_wen, retire, trap;
   logic [31:0]     pc, instruction, trap_pc, trap_addr;
   logic [CW-1:0]   instret;
   logic [1:0]      trap_cause;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.XLEN(XLEN)) mif ();

   multicycle_ctrl #(
      .XLEN(XLEN), .RESET_PC(RPC), .TRAP_VECTOR(TVEC), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .mem(mif),
      .action_type(action_type), .func3(func3), .pc_next(pc_next),
      .immediate(immediate), .rs1_data(rs1_data),
      .reg_wen(reg_wen), .pc(pc), .instruction(instruction),
      .retire(retire), .instret(instret), .trap(trap),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_addr(trap_addr)
   );

   typedef struct {
      logic [2:0]  act;
      logic [2:0]  f3;
      logic [31:0] rs1, imm, pcn, word;
      int          fw, dw;
      bit          x_trap;
      logic [1:0]  x_cause;
      logic [31:0] x_taddr;
      int          x_cycles;
      bit          x_regwen, x_memwen;
      logic [31:0] x_maddr;
   } vec_t;

   typedef struct {
      bit          is_trap;
      logic [1:0]  cause;
      logic [31:0] tpc, taddr, pc_after;
      logic [CW-1:0] cnt_after;
   } evt_t;

   evt_t          sbq[$];
   vec_t          vecs[17];
   logic [31:0]   m_pc;
   logic [CW-1:0] m_cnt;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] act, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] pcn, input int fw, input int dw,
                               input bit xt, input logic [1:0] xc, input logic [31:0] xa,
                               input int xcyc, input bit xrw, input bit xmw,
                               input logic [31:0] xma);
      vec_t v;
      v.act = act; v.f3 = f3; v.rs1 = rs1; v.imm = imm; v.pcn = pcn; v.word = 32'h0;
      v.fw = fw; v.dw = dw; v.x_trap = xt; v.x_cause = xc; v.x_taddr = xa;
      v.x_cycles = xcyc; v.x_regwen = xrw; v.x_memwen = xmw; v.x_maddr = xma;
      return v;
   endfunction

   // Runs one instruction from its FETCH cycle until it retires or traps.
   task automatic run_instr(input vec_t v, input string tag);
      evt_t e, got;
      int   cyc, acc, wcnt, dcyc;
      bit   done, seen_trap, seen_rw, seen_mw, bad_stable, bad_rw, bad_idle;
      bit   is_mem;
      logic [1:0] s_cause;
      logic [31:0] s_tpc, s_taddr;
      e.is_trap   = v.x_trap;
      e.cause     = v.x_cause;
      e.tpc       = m_pc;
      e.taddr     = v.x_taddr;
      e.pc_after  = v.x_trap ? TVEC : v.pcn;
      e.cnt_after = v.x_trap ? m_cnt : m_cnt + CW'(1);
      sbq.push_back(e);
      action_type = v.act; func3 = v.f3; rs1_data = v.rs1;
      immediate = v.imm; pc_next = v.pcn;
      cyc = 0; acc = 0; wcnt = 0; dcyc = 0;
      done = 0; seen_trap = 0; seen_rw = 0; seen_mw = 0;
      bad_stable = 0; bad_rw = 0; bad_idle = 0;
      s_cause = 0; s_tpc = 0; s_taddr = 0;
      while (!done && cyc < 64) begin
         if (mif.mem_req) begin
            mif.mem_ready = (wcnt == ((acc == 0) ? v.fw : v.dw));
            mif.mem_rdata = (acc == 0) ? v.word : (32'hD00D_0000 + 32'(cyc));
         end else begin
            mif.mem_ready = 1'b1;
            mif.mem_rdata = 32'hBAD0_BAD0;
         end
         #1;
         if (cyc == 0) begin
            check({tag, ".fetch_req"}, mif.mem_req, 1'b1);
            check({tag, ".fetch_addr"}, mif.mem_addr, m_pc);
         end
         if (mif.mem_req && acc == 0 &&
             (mif.mem_addr !== m_pc || mif.mem_func3 !== 3'b010 || mif.mem_wen !== 1'b0))
            bad_stable = 1;
         if (mif.mem_req && acc == 1) begin
            dcyc++;
            if (mif.mem_addr !== v.x_maddr || mif.mem_func3 !== v.f3 || mif.mem_wen !== v.x_memwen)
               bad_stable = 1;
         end
         if (!mif.mem_req && (mif.mem_addr !== 32'h0 || mif.mem_wen !== 1'b0)) bad_idle = 1;
         if (mif.mem_wen) seen_mw = 1;
         if (reg_wen) begin
            seen_rw = 1;
            if (!retire || (mif.mem_req && !mif.mem_ready)) bad_rw = 1;
         end
         if (retire || trap) begin
            done = 1;
            seen_trap = trap;
            s_cause = trap_cause; s_tpc = trap_pc; s_taddr = trap_addr;
         end
         if (mif.mem_req) begin
            if (mif.mem_ready) begin acc++; wcnt = 0; end
            else wcnt++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      check({tag, ".completed"}, done, 1'b1);
      if (sbq.size() == 0) begin
         check({tag, ".sb_nonempty"}, 1'b0, 1'b1);
      end else begin
         got = sbq.pop_front();
         check({tag, ".trapped"}, seen_trap, got.is_trap);
         if (got.is_trap) begin
            check({tag, ".trap_cause"}, s_cause, got.cause);
            check({tag, ".trap_pc"}, s_tpc, got.tpc);
            if (got.cause != 2'd0) check({tag, ".trap_addr"}, s_taddr, got.taddr);
         end
         check({tag, ".pc_after"}, pc, got.pc_after);
         check({tag, ".instret_after"}, instret, got.cnt_after);
      end
      is_mem = (v.act == LD || v.act == ST) && !v.x_trap;
      check({tag, ".cycles"}, cyc, v.x_cycles);
      check({tag, ".data_cycles"}, dcyc, is_mem ? v.dw + 1 : 0);
      check({tag, ".reg_wen"}, seen_rw, v.x_regwen);
      check({tag, ".mem_wen"}, seen_mw, v.x_memwen);
      check({tag, ".bus_stable"}, bad_stable, 1'b0);
      check({tag, ".reg_wen_timing"}, bad_rw, 1'b0);
      check({tag, ".idle_bus"}, bad_idle, 1'b0);
      check({tag, ".instruction"}, instruction, v.word);
      m_pc  = got.pc_after;
      m_cnt = got.cnt_after;
   endtask

   initial begin
      vec_t v;
      // act f3 rs1 imm pc_next fw dw | trap cause taddr cycles regwen memwen maddr
      vecs[0]  = mk(RG, 3'd0, 32'h0, 32'h0, 32'h44, 0, 0, 0, 2'd0, 32'h0, 2, 1, 0, 32'h0);
      vecs[1]  = mk(LD, 3'd2, 32'h1000, 32'h8, 32'h48, 0, 2, 0, 2'd0, 32'h0, 5, 1, 0, 32'h1008);
      vecs[2]  = mk(ST, 3'd1, 32'h2000, 32'h2, 32'h4c, 0, 1, 0, 2'd0, 32'h0, 4, 0, 1, 32'h2002);
      vecs[3]  = mk(ST, 3'd1, 32'h2000, 32'h3, 32'h50, 0, 0, 1, 2'd2, 32'h2003, 3, 0, 0, 32'h0);
      vecs[4]  = mk(3'd7, 3'd0, 32'h0, 32'h0, 32'h104, 0, 0, 1, 2'd0, 32'h0, 3, 0, 0, 32'h0);
      vecs[5]  = mk(BR, 3'd0, 32'h0, 32'h0, 32'h46, 0, 0, 1, 2'd3, 32'h46, 3, 0, 0, 32'h0);
      vecs[6]  = mk(JL, 3'd0, 32'h0, 32'h0, 32'h200, 1, 0, 0, 2'd0, 32'h0, 3, 1, 0, 32'h0);
      vecs[7]  = mk(BR, 3'd0, 32'h0, 32'h0, 32'h300, 2, 0, 0, 2'd0, 32'h0, 4, 0, 0, 32'h0);
      vecs[8]  = mk(LD, 3'd0, 32'h1000, 32'h3, 32'h304, 0, 0, 0, 2'd0, 32'h0, 3, 1, 0, 32'h1003);
      vecs[9]  = mk(LD, 3'd3, 32'h1000, 32'h0, 32'h308, 0, 0, 1, 2'd1, 32'h1000, 3, 0, 0, 32'h0);
      vecs[10] = mk(LD, 3'd5, 32'h1001, 32'h0, 32'h308, 0, 0, 1, 2'd1, 32'h1001, 3, 0, 0, 32'h0);
      vecs[11] = mk(LD, 3'd2, 32'h1000, 32'h2, 32'h308, 0, 0, 1, 2'd1, 32'h1002, 3, 0, 0, 32'h0);
      vecs[12] = mk(ST, 3'd2, 32'hFFFF_FFFC, 32'h8, 32'h104, 1, 3, 0, 2'd0, 32'h0, 7, 0, 1, 32'h4);
      vecs[13] = mk(JL, 3'd0, 32'h0, 32'h0, 32'h10A, 0, 0, 1, 2'd3, 32'h10A, 3, 0, 0, 32'h0);
      vecs[14] = mk(3'd5, 3'd0, 32'h0, 32'h0, 32'h104, 0, 0, 1, 2'd0, 32'h0, 3, 0, 0, 32'h0);
      vecs[15] = mk(RG, 3'd0, 32'h0, 32'h0, 32'h123, 0, 0, 0, 2'd0, 32'h0, 2, 1, 0, 32'h0);
      vecs[16] = mk(LD, 3'd1, 32'h2000, 32'hFFFF_FFFE, 32'h128, 0, 1, 0, 2'd0, 32'h0, 4, 1, 0, 32'h1FFE);
      for (int i = 0; i < 17; i++) vecs[i].word = 32'hC0DE_0000 | 32'(i);

      reset = 1'b1;
      action_type = RG; func3 = 3'd0; pc_next = 32'h0; immediate = 32'h0; rs1_data = 32'h0;
      mif.mem_ready = 1'b0; mif.mem_rdata = 32'h0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("rst.mem_req_held", mif.mem_req, 1'b0);
      check("rst.reg_wen_held", reg_wen, 1'b0);
      reset = 1'b0;
      #1;
      check("rst.pc", pc, RPC);
      check("rst.instret", instret, 0);
      check("rst.instruction", instruction, 0);
      check("rst.trap_cause", trap_cause, 0);
      check("rst.trap_pc", trap_pc, 0);
      check("rst.trap_addr", trap_addr, 0);
      check("rst.mem_req", mif.mem_req, 1'b1);
      check("rst.mem_addr", mif.mem_addr, RPC);
      check("rst.retire", retire, 1'b0);
      check("rst.trap", trap, 1'b0);
      m_pc = RPC; m_cnt = '0;

      for (int i = 0; i < 17; i++) run_instr(vecs[i], $sformatf("v%0d", i));

      // Trap record persists across the retirements that followed the last trap
      check("hold.trap_cause", trap_cause, 2'd0);

      // Asynchronous reset while a load waits in MEMORY
      action_type = LD; func3 = 3'd2; rs1_data = 32'h3000; immediate = 32'h4; pc_next = m_pc + 4;
      mif.mem_ready = 1'b1; mif.mem_rdata = 32'h0000_1111;
      @(posedge clk); #1;
      mif.mem_ready = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      mif.mem_ready = 1'b0;
      #1;
      check("arst.in_memory_req", mif.mem_req, 1'b1);
      check("arst.in_memory_addr", mif.mem_addr, 32'h3004);
      check("arst.reg_wen_waiting", reg_wen, 1'b0);
      mif.mem_ready = 1'b1;
      #1;
      check("arst.reg_wen_ready", reg_wen, 1'b1);
      reset = 1'b1;
      #1;
      check("arst.mem_req_drop", mif.mem_req, 1'b0);
      check("arst.reg_wen_drop", reg_wen, 1'b0);
      check("arst.retire_drop", retire, 1'b0);
      check("arst.pc", pc, RPC);
      check("arst.instret", instret, 0);
      mif.mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("arst.rel_mem_req", mif.mem_req, 1'b1);
      check("arst.rel_mem_addr", mif.mem_addr, RPC);
      check("arst.rel_instret", instret, 0);
      m_pc = RPC; m_cnt = '0;
      sbq.delete();
      @(posedge clk); #1;

      // Counter wrap: 17 retirements on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         v = mk(RG, 3'd0, 32'h0, 32'h0, m_pc + 32'h4, 0, 0, 0, 2'd0, 32'h0, 2, 1, 0, 32'h0);
         v.word = 32'h0000_0033 | (32'(i) << 7);
         run_instr(v, $sformatf("wrap%0d", i));
      end
      check("wrap.instret", instret, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
